// File: rtl/accel_pkg.sv
// accel_pkg: shared opcodes, register indices, instruction word and FSM states (ACCEL_SEQ_STEP_EN adds HOLD)
package accel_pkg;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_B = 2'd1;
  localparam logic [1:0] REG_C = 2'd2;
  localparam logic [1:0] REG_D = 2'd3;
  localparam int CNT_W = 3;
  typedef struct packed {
    logic       halt;
    logic [1:0] dst;
    logic [1:0] sel_b;
    logic [1:0] sel_a;
    logic [3:0] op;
  } instr_t;
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_WB, S_DONE
`ifdef ACCEL_SEQ_STEP_EN
    , S_HOLD
`endif
  } state_t;
endpackage

// File: rtl/accel_sequencer_if.sv
// accel_sequencer_if: host/ALU bundle of the sequencer (ACCEL_SEQ_STEP_EN adds step/step_mode)
interface accel_sequencer_if #(parameter int DEPTH = 8);
  localparam int AW = $clog2(DEPTH);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [10:0]   prog_data;
  logic          start;
  logic          abort;
  logic [7:0]    alu_result;
  logic [3:0]    alu_op;
  logic [1:0]    alu_sel_a;
  logic [1:0]    alu_sel_b;
  logic          wb_en;
  logic [1:0]    wb_dst;
  logic [7:0]    wb_data;
  logic          busy;
  logic          done;
  logic          prog_err;
  logic [AW-1:0] pc;
`ifdef ACCEL_SEQ_STEP_EN
  logic          step;
  logic          step_mode;
`endif
  modport master (
`ifdef ACCEL_SEQ_STEP_EN
    output step, step_mode,
`endif
    output prog_we, prog_addr, prog_data, start, abort, alu_result,
    input  alu_op, alu_sel_a, alu_sel_b, wb_en, wb_dst, wb_data, busy, done, prog_err, pc
  );
  modport slave (
`ifdef ACCEL_SEQ_STEP_EN
    input  step, step_mode,
`endif
    input  prog_we, prog_addr, prog_data, start, abort, alu_result,
    output alu_op, alu_sel_a, alu_sel_b, wb_en, wb_dst, wb_data, busy, done, prog_err, pc
  );
endinterface

// File: rtl/accel_seq_progmem.sv
// accel_seq_progmem: flop-based program store, one write port, one async read port, cleared on reset
module accel_seq_progmem
  import accel_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  instr_t        i_wdata,
  input  logic [AW-1:0] i_raddr,
  output instr_t        o_rdata
);
  instr_t r_mem [DEPTH];
  // entry write; the whole array clears on reset
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/accel_sequencer.sv
// accel_sequencer: issues a host-loaded ALU micro-program and writes results back (ACCEL_SEQ_STEP_EN: single-step HOLD)
module accel_sequencer
  import accel_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 1
) (
  input logic clk,
  input logic rst,
  accel_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_t           r_state, w_next, w_adv;
  logic [AW-1:0]    r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic [1:0]       r_sel_a, r_sel_b;
  logic [7:0]       r_res;
  logic             r_err;
  instr_t           w_instr;
  logic             w_last;
  accel_seq_progmem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (bus.prog_we && r_state == S_IDLE),
    .i_waddr (bus.prog_addr),
    .i_wdata (instr_t'(bus.prog_data)),
    .i_raddr (r_pc),
    .o_rdata (w_instr)
  );
  assign w_last = w_instr.halt || r_pc == AW'(DEPTH - 1);
  assign w_adv  = w_last ? S_DONE : S_ISSUE;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state; abort overrides everything, including start in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.start ? S_ISSUE : S_IDLE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = r_cnt == CNT_W'(1) ? S_WB : S_WAIT;
      S_WB:    w_next = `ifdef ACCEL_SEQ_STEP_EN bus.step_mode ? S_HOLD : `endif w_adv;
`ifdef ACCEL_SEQ_STEP_EN
      S_HOLD:  w_next = bus.step ? w_adv : S_HOLD;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.abort) w_next = S_IDLE;
  end
  // pc, ALU controls latched at ISSUE, latency counter, result capture, write-while-busy flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc    <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_sel_a <= '0;
      r_sel_b <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= bus.prog_we && r_state != S_IDLE;
      if (w_next == S_ISSUE) r_pc <= r_state == S_IDLE ? '0 : r_pc + 1'b1;
      if (r_state == S_ISSUE) begin
        r_op    <= w_instr.op;
        r_sel_a <= w_instr.sel_a;
        r_sel_b <= w_instr.sel_b;
        r_cnt   <= CNT_W'(ALU_LAT);
      end
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) r_res <= bus.alu_result;
      end
    end
  assign bus.alu_op    = r_op;
  assign bus.alu_sel_a = r_sel_a;
  assign bus.alu_sel_b = r_sel_b;
  assign bus.wb_en     = r_state == S_WB;
  assign bus.wb_dst    = bus.wb_en ? w_instr.dst : '0;
  assign bus.wb_data   = bus.wb_en ? r_res : '0;
  assign bus.done      = r_state == S_DONE;
  assign bus.busy      = r_state != S_IDLE;
  assign bus.prog_err  = r_err;
  assign bus.pc        = r_pc;
endmodule

// File: tb/tb_accel_sequencer.sv
// tb_accel_sequencer: table, directed and random programs checked against a behavioural program/ALU model
module tb_accel_sequencer;
  import accel_pkg::*;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int LAT   = 3;
  localparam int PER   = 2 + LAT;
  typedef struct { int cyc; int dst; int data; } wb_t;
  typedef struct {
    logic [3:0] op;
    logic [1:0] sa, sb, dst;
    int ra, rb, rc, rd;
    int exp_dst, exp_data;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld  = 1'b0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int done_pc = 0;
  int both_hi = 0;
  wb_t wb_q[$];
  int done_q[$];
  logic [7:0] rf [4];
  logic [7:0] rf_init [4];
  instr_t prog [DEPTH];
  vec_t tbl [6];
  always #5 clk = ~clk;
  accel_sequencer_if #(.DEPTH(DEPTH)) bus ();
  accel_sequencer #(.DEPTH(DEPTH), .ALU_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  // bench ALU: register file written by the sequencer's write-backs
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (ld) rf <= rf_init;
    else if (bus.wb_en) rf[bus.wb_dst] <= bus.wb_data;
  assign bus.alu_result = bus.alu_op == OP_ADD ? rf[bus.alu_sel_a] + rf[bus.alu_sel_b] :
                          bus.alu_op == OP_SUB ? rf[bus.alu_sel_a] - rf[bus.alu_sel_b] : 8'h00;
  // monitor: logs write-backs and done pulses mid-cycle
  always @(negedge clk) begin
    if (bus.wb_en) wb_q.push_back('{cyc, int'(bus.wb_dst), int'(bus.wb_data)});
    if (bus.wb_en && bus.done) both_hi++;
    if (bus.done) begin
      done_q.push_back(cyc);
      done_pc = int'(bus.pc);
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic instr_t mk(input logic [3:0] op, input logic [1:0] sa, sb, dst, input logic halt);
    instr_t t;
    t.op = op; t.sel_a = sa; t.sel_b = sb; t.dst = dst; t.halt = halt;
    return t;
  endfunction
  task automatic load(input int a, input instr_t d);
    bus.prog_addr = AW'(a);
    bus.prog_data = d;
    bus.prog_we = 1'b1;
    tick();
    bus.prog_we = 1'b0;
    prog[a] = d;
  endtask
  task automatic set_regs(input int a, b, c, d);
    rf_init[0] = 8'(a); rf_init[1] = 8'(b); rf_init[2] = 8'(c); rf_init[3] = 8'(d);
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && bus.busy; i++) tick();
    chk("idle_wait", int'(bus.busy), 0);
  endtask
  // starts the program and compares every write-back and done against the model
  task automatic run_check(input string tag, output int base, output int nwb);
    int m[4];
    int ed[$];
    int ev[$];
    int r, c, dbase;
    for (int i = 0; i < 4; i++) m[i] = int'(rf_init[i]);
    for (int i = 0; i < DEPTH; i++) begin
      r = prog[i].op == OP_ADD ? (m[prog[i].sel_a] + m[prog[i].sel_b]) & 255 :
          prog[i].op == OP_SUB ? (m[prog[i].sel_a] - m[prog[i].sel_b]) & 255 : 0;
      m[prog[i].dst] = r;
      ed.push_back(int'(prog[i].dst));
      ev.push_back(r);
      if (prog[i].halt) break;
    end
    base = wb_q.size();
    dbase = done_q.size();
    c = cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < DEPTH * PER + 20 && done_q.size() == dbase; i++) tick();
    tick();
    nwb = wb_q.size() - base;
    chk({tag, "_done_cnt"}, done_q.size() - dbase, 1);
    chk({tag, "_wb_cnt"}, nwb, ed.size());
    for (int k = 0; k < ed.size() && k < nwb; k++) begin
      chk($sformatf("%s_wb%0d_cyc", tag, k), wb_q[base + k].cyc - c, (k + 1) * PER);
      chk($sformatf("%s_wb%0d_dst", tag, k), wb_q[base + k].dst, ed[k]);
      chk($sformatf("%s_wb%0d_data", tag, k), wb_q[base + k].data, ev[k]);
    end
    if (done_q.size() > dbase) chk({tag, "_done_cyc"}, done_q[dbase] - c, ed.size() * PER + 1);
    chk({tag, "_done_pc"}, done_pc, ed.size() - 1);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int base, nwb, c, dbase, t, idle_seen;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 1'b0; bus.abort = 1'b0;
`ifdef ACCEL_SEQ_STEP_EN
    bus.step = 1'b0; bus.step_mode = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    tbl = '{
      '{OP_ADD, REG_A, REG_B, REG_C, 5, 7, 0, 0, 2, 12},
      '{OP_SUB, REG_A, REG_B, REG_D, 10, 3, 0, 0, 3, 7},
      '{OP_SUB, REG_B, REG_A, REG_A, 10, 3, 0, 0, 0, 249},
      '{OP_ADD, REG_C, REG_D, REG_B, 0, 0, 200, 100, 1, 44},
      '{4'hF, REG_A, REG_B, REG_D, 5, 7, 1, 1, 3, 0},
      '{OP_ADD, REG_D, REG_D, REG_A, 0, 0, 0, 128, 0, 0}
    };
    tick(2);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_wb_en", int'(bus.wb_en), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_prog_err", int'(bus.prog_err), 0);
    chk("rst_alu_op", int'(bus.alu_op), 0);
    rst = 1'b0;
    tick();
    for (int v = 0; v < 6; v++) begin
      load(0, mk(tbl[v].op, tbl[v].sa, tbl[v].sb, tbl[v].dst, 1'b1));
      set_regs(tbl[v].ra, tbl[v].rb, tbl[v].rc, tbl[v].rd);
      run_check($sformatf("tbl%0d", v), base, nwb);
      if (nwb > 0) begin
        chk($sformatf("tbl%0d_dst", v), wb_q[base].dst, tbl[v].exp_dst);
        chk($sformatf("tbl%0d_data", v), wb_q[base].data, tbl[v].exp_data);
      end
    end
    load(0, mk(OP_SUB, REG_A, REG_B, REG_D, 1'b0));
    chk("idle_write_no_err", int'(bus.prog_err), 0);
    load(1, mk(OP_ADD, REG_D, REG_D, REG_A, 1'b0));
    load(2, mk(OP_ADD, REG_A, REG_C, REG_B, 1'b1));
    set_regs(10, 3, 1, 0);
    run_check("chain", base, nwb);
    if (nwb == 3) begin
      chk("chain_wb0", wb_q[base].dst * 256 + wb_q[base].data, 3 * 256 + 7);
      chk("chain_wb1", wb_q[base + 1].dst * 256 + wb_q[base + 1].data, 0 * 256 + 14);
      chk("chain_wb2", wb_q[base + 2].dst * 256 + wb_q[base + 2].data, 1 * 256 + 15);
    end
    set_regs(10, 3, 1, 0);
    base = wb_q.size();
    dbase = done_q.size();
    c = cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(PER + 1);
    chk("abort_in_wait_pc", int'(bus.pc), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_pc", int'(bus.pc), 1);
    tick(20);
    chk("abort_wb_cnt", wb_q.size() - base, 1);
    chk("abort_done_cnt", done_q.size() - dbase, 0);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_beats_start", int'(bus.busy), 0);
    set_regs(10, 3, 1, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = 11'h7FF;
    bus.prog_we = 1'b1;
    tick();
    bus.prog_we = 1'b0;
    chk("prog_err_pulse", int'(bus.prog_err), 1);
    tick();
    chk("prog_err_clear", int'(bus.prog_err), 0);
    wait_idle();
    set_regs(10, 3, 1, 0);
    run_check("after_busy_write", base, nwb);
    for (int i = 0; i < DEPTH; i++)
      load(i, mk(4'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0));
    set_regs($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    run_check("nohalt", base, nwb);
    chk("nohalt_count", nwb, 8);
    chk("nohalt_pc", done_pc, 7);
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < DEPTH; i++)
        load(i, mk(4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0)));
      set_regs($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      run_check($sformatf("rnd%0d", n), base, nwb);
    end
`ifdef ACCEL_SEQ_STEP_EN
    load(0, mk(OP_ADD, REG_A, REG_B, REG_C, 1'b0));
    load(1, mk(OP_ADD, REG_C, REG_C, REG_D, 1'b1));
    set_regs(1, 2, 0, 0);
    bus.step_mode = 1'b1;
    base = wb_q.size();
    dbase = done_q.size();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(PER);
    idle_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) idle_seen++;
      tick();
    end
    chk("hold_busy_drops", idle_seen, 0);
    chk("hold_wb_cnt", wb_q.size() - base, 1);
    t = cyc;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    for (int i = 0; i < 50 && wb_q.size() < base + 2; i++) tick();
    chk("step_wb_cnt", wb_q.size() - base, 2);
    if (wb_q.size() >= base + 2) begin
      chk("step_wb_cyc", wb_q[base + 1].cyc - t, PER);
      chk("step_wb_data", wb_q[base + 1].data, 6);
      chk("step_wb_dst", wb_q[base + 1].dst, 3);
    end
    tick(3);
    chk("hold_before_done", done_q.size() - dbase, 0);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick(2);
    chk("step_done", done_q.size() - dbase, 1);
    bus.step_mode = 1'b0;
    wait_idle();
`endif
    load(0, mk(OP_SUB, REG_A, REG_B, REG_D, 1'b0));
    load(1, mk(OP_ADD, REG_D, REG_D, REG_A, 1'b0));
    set_regs(1, 2, 3, 4);
    base = wb_q.size();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_pc", int'(bus.pc), 0);
    chk("midrst_wb_en", int'(bus.wb_en), 0);
    chk("midrst_alu_op", int'(bus.alu_op), 0);
    tick();
    rst = 1'b0;
    tick(LAT + 3);
    chk("midrst_no_wb", wb_q.size() - base, 0);
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    set_regs(9, 1, 2, 3);
    run_check("cleared", base, nwb);
    chk("wb_done_overlap", both_hi, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
